// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_next;
  } fetch_entry_t;

  localparam logic [15:0] FETCH_NOP       = 16'h0800;
  localparam int          FETCH_BUF_DEPTH = 2;

endpackage

// File: rtl/fetch_inst_buf.sv
// Two-entry instruction FIFO; head is presented combinationally, flush wins over push/pop.
module fetch_inst_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t entry,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [FETCH_BUF_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         push_ok;
  logic         pop_ok;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'(FETCH_BUF_DEPTH)) || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem request, 2-entry buffer, redirect/halt.
// Optional FETCH_ALIGN_CHECK_EN: odd redirect targets set sticky err and are forced even.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = FETCH_NOP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_in,
  input  logic         redirect_in,
  input  logic [15:0]  redirect_pc,
  input  logic         halt_in,
  output logic         imem_req,
  output logic [15:0]  imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [15:0]  imem_rdata,
  output logic         inst_valid,
  output logic [15:0]  instruction,
  output logic [15:0]  pc_next,
  output logic         err,
  output fetch_state_t dbg_state
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  issued_addr;
  logic [15:0]  target;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         can_req;
  logic         fire;
  logic         pop;
  logic         push;
  logic         flush;
  logic         redir_go;
  logic         pending_after;

  // Handshakes: a request transfers when imem_req && imem_gnt in the same cycle; exactly one
  // imem_rvalid answers it later. Downstream consumes the head when inst_valid && !stall_in.
  assign inst_valid = (count != 2'd0) && (state != HALTED);
  assign pop        = inst_valid && !stall_in;
  assign redir_go   = redirect_in && !halt_in && (state != HALTED);

  always_comb begin
    can_req = 1'b0;
    case (state)
      RUN:     can_req = (count < 2'(FETCH_BUF_DEPTH));
      WAIT:    can_req = imem_rvalid && ((count == 2'd0) || ((count == 2'd1) && pop));
      default: can_req = 1'b0;
    endcase
  end

  assign imem_req  = rst && can_req && !redirect_in && !halt_in;
  assign fire      = imem_req && imem_gnt;
  assign imem_addr = pc;

  // A response in flight (or granted right now) must be swallowed after a redirect.
  assign pending_after = (((state == WAIT) || (state == DRAIN)) && !imem_rvalid) || imem_gnt;

  assign push       = (state == WAIT) && imem_rvalid && !redir_go && !halt_in;
  assign flush      = halt_in || redir_go || (state == HALTED);
  assign push_entry = {imem_rdata, issued_addr + 16'd2};

  fetch_inst_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .entry (push_entry),
    .count (count),
    .head  (head)
  );

  assign instruction = inst_valid ? head.instr : NOP_INST;
  assign pc_next     = inst_valid ? head.pc_next : pc + 16'd2;
  assign dbg_state   = state;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;
  assign target = {redirect_pc[15:1], 1'b0};
  assign err    = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else if (redir_go && redirect_pc[0]) err_q <= 1'b1;
  end
`else
  assign target = redirect_pc;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      issued_addr <= RESET_PC;
    end else begin
      if (fire) issued_addr <= pc;
      if (halt_in || (state == HALTED)) begin
        state <= HALTED;
      end else if (redirect_in) begin
        pc    <= target;
        state <= pending_after ? DRAIN : RUN;
      end else begin
        if (fire) pc <= pc + 16'd2;
        case (state)
          RUN:     if (fire) state <= WAIT;
          WAIT:    if (imem_rvalid) state <= fire ? WAIT : RUN;
          DRAIN:   if (imem_rvalid) state <= RUN;
          default: state <= HALTED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus reset/alignment sequences.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic         clk;
  logic         rst;
  logic         stall_in;
  logic         redirect_in;
  logic [15:0]  redirect_pc;
  logic         halt_in;
  logic         imem_req;
  logic [15:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [15:0]  imem_rdata;
  logic         inst_valid;
  logic [15:0]  instruction;
  logic [15:0]  pc_next;
  logic         err;
  fetch_state_t dbg_state;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [15:0] ALIGN_ADDR = 16'h0012;
  localparam logic [15:0] ALIGN_ERR  = 16'd1;
`else
  localparam logic [15:0] ALIGN_ADDR = 16'h0013;
  localparam logic [15:0] ALIGN_ERR  = 16'd0;
`endif

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall_in    (stall_in),
    .redirect_in (redirect_in),
    .redirect_pc (redirect_pc),
    .halt_in     (halt_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .instruction (instruction),
    .pc_next     (pc_next),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        halt;
    logic        gnt;
    logic        rv;
    logic [15:0] rdata;
    logic        req;
    logic [15:0] addr;
    logic        iv;
    logic [15:0] ins;
    logic [15:0] pcn;
  } vec_t;

  localparam int NVEC = 26;
  vec_t        tbl [NVEC];
  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic vec_t mk(input logic st, input logic rd, input logic [15:0] rpc,
                              input logic hl, input logic gn, input logic rv,
                              input logic [15:0] rdat, input logic req,
                              input logic [15:0] addr, input logic iv,
                              input logic [15:0] ins, input logic [15:0] pcn);
    vec_t v;
    v.stall = st;  v.redir = rd;   v.rpc = rpc; v.halt = hl;
    v.gnt   = gn;  v.rv    = rv;   v.rdata = rdat;
    v.req   = req; v.addr  = addr; v.iv = iv;   v.ins = ins; v.pcn = pcn;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic st, input logic rd, input logic [15:0] rpc,
                       input logic hl, input logic gn, input logic rv,
                       input logic [15:0] rdat);
    stall_in    = st;
    redirect_in = rd;
    redirect_pc = rpc;
    halt_in     = hl;
    imem_gnt    = gn;
    imem_rvalid = rv;
    imem_rdata  = rdat;
  endtask

  task automatic check_reset_outs(input int idx);
    check("rst_req",   idx, {15'd0, imem_req},   16'd0);
    check("rst_addr",  idx, imem_addr,           16'h0000);
    check("rst_valid", idx, {15'd0, inst_valid}, 16'd0);
    check("rst_instr", idx, instruction,         16'h0800);
    check("rst_pcnext",idx, pc_next,             16'h0002);
    check("rst_err",   idx, {15'd0, err},        16'd0);
  endtask

  initial begin
    //                 st rd rpc       hl gn rv rdata     req addr      iv instr     pc_next
    tbl[0]  = mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0800, 16'h0002);
    tbl[1]  = mk(0, 0, 16'h0000, 0, 1, 1, 16'h1111, 1, 16'h0002, 0, 16'h0800, 16'h0004);
    tbl[2]  = mk(0, 0, 16'h0000, 0, 1, 1, 16'h2222, 1, 16'h0004, 1, 16'h1111, 16'h0002);
    tbl[3]  = mk(1, 0, 16'h0000, 0, 0, 1, 16'h3333, 0, 16'h0006, 1, 16'h2222, 16'h0004);
    for (int i = 4; i < 8; i++)
      tbl[i] = mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0006, 1, 16'h2222, 16'h0004);
    tbl[8]  = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0006, 1, 16'h2222, 16'h0004);
    tbl[9]  = mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0006, 1, 16'h3333, 16'h0006);
    tbl[10] = mk(0, 0, 16'h0000, 0, 1, 1, 16'h4444, 1, 16'h0008, 0, 16'h0800, 16'h000a);
    tbl[11] = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h000a, 1, 16'h4444, 16'h0008);
    tbl[12] = mk(0, 1, 16'h0040, 0, 0, 0, 16'h0000, 0, 16'h000a, 0, 16'h0800, 16'h000c);
    tbl[13] = mk(0, 0, 16'h0000, 0, 0, 1, 16'h5555, 0, 16'h0040, 0, 16'h0800, 16'h0042);
    tbl[14] = mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0040, 0, 16'h0800, 16'h0042);
    tbl[15] = mk(0, 0, 16'h0000, 0, 0, 1, 16'h6666, 1, 16'h0042, 0, 16'h0800, 16'h0044);
    tbl[16] = mk(0, 1, 16'h0050, 0, 0, 0, 16'h0000, 0, 16'h0042, 1, 16'h6666, 16'h0042);
    tbl[17] = mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0050, 0, 16'h0800, 16'h0052);
    tbl[18] = mk(0, 0, 16'h0000, 0, 1, 1, 16'h7777, 1, 16'h0052, 0, 16'h0800, 16'h0054);
    tbl[19] = mk(1, 1, 16'h0080, 0, 0, 0, 16'h0000, 0, 16'h0054, 1, 16'h7777, 16'h0052);
    tbl[20] = mk(0, 0, 16'h0000, 0, 0, 1, 16'h8888, 0, 16'h0080, 0, 16'h0800, 16'h0082);
    tbl[21] = mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0080, 0, 16'h0800, 16'h0082);
    tbl[22] = mk(0, 0, 16'h0000, 0, 0, 1, 16'h9999, 1, 16'h0082, 0, 16'h0800, 16'h0084);
    tbl[23] = mk(0, 1, 16'h00c0, 1, 0, 0, 16'h0000, 0, 16'h0082, 1, 16'h9999, 16'h0082);
    tbl[24] = mk(0, 0, 16'h0000, 0, 0, 1, 16'haaaa, 0, 16'h0082, 0, 16'h0800, 16'h0084);
    tbl[25] = mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0082, 0, 16'h0800, 16'h0084);

    // instructions that must be consumed, in order, by the table run
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333);
    exp_q.push_back(16'h4444);

    drive(0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outs(-1);
    check("rst_state", -1, 16'(dbg_state), 16'(RUN));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].halt, tbl[i].gnt, tbl[i].rv,
            tbl[i].rdata);
      #1;
      check("req",     i, {15'd0, imem_req},   {15'd0, tbl[i].req});
      check("addr",    i, imem_addr,           tbl[i].addr);
      check("valid",   i, {15'd0, inst_valid}, {15'd0, tbl[i].iv});
      check("instr",   i, instruction,         tbl[i].ins);
      check("pc_next", i, pc_next,             tbl[i].pcn);
      check("err",     i, {15'd0, err},        16'd0);
      // scoreboard: every consumed head must match the next expected instruction
      if (inst_valid && !stall_in && !redirect_in && !halt_in) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_extra step %0d: got %h expected none", i, instruction);
        end else begin
          check("sb_pop", i, instruction, exp_q.pop_front());
        end
      end
      @(negedge clk);
    end
    check("sb_left", NVEC, 16'(exp_q.size()), 16'd0);
    check("halted",  NVEC, 16'(dbg_state), 16'(HALTED));

    // reset exits HALTED
    drive(0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    rst = 1'b0;
    #1 check_reset_outs(100);
    check("rst_state", 100, 16'(dbg_state), 16'(RUN));

    // odd redirect target
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1, 16'h0013, 0, 0, 0, 16'h0000);
    #1;
    check("al_req0",  101, {15'd0, imem_req}, 16'd0);
    check("al_addr0", 101, imem_addr,         16'h0000);
    @(negedge clk);
    drive(0, 0, 16'h0000, 0, 1, 0, 16'h0000);
    #1;
    check("al_req1",  102, {15'd0, imem_req}, 16'd1);
    check("al_addr1", 102, imem_addr,         ALIGN_ADDR);
    check("al_err1",  102, {15'd0, err},      ALIGN_ERR);
    @(negedge clk);
    drive(0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    #1;
    check("al_req2",  103, {15'd0, imem_req}, 16'd0);
    check("al_addr2", 103, imem_addr,         ALIGN_ADDR + 16'd2);
    check("al_err2",  103, {15'd0, err},      ALIGN_ERR);
    check("al_wait",  103, 16'(dbg_state),    16'(WAIT));

    // reset while a request is outstanding; late response must be ignored
    rst = 1'b0;
    #1 check_reset_outs(104);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 16'h0000, 0, 0, 1, 16'hbbbb);
    #1;
    check("late_req",   105, {15'd0, imem_req},   16'd1);
    check("late_addr",  105, imem_addr,           16'h0000);
    check("late_valid", 105, {15'd0, inst_valid}, 16'd0);
    @(negedge clk);
    drive(0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    #1;
    check("late_valid2", 106, {15'd0, inst_valid}, 16'd0);
    check("late_instr",  106, instruction,         16'h0800);
    check("late_req2",   106, {15'd0, imem_req},   16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit five-stage pipeline, feeding the IF_ID latch. It owns the PC register and a request/response interface to instruction memory with at most one outstanding request. A 2-entry instruction buffer absorbs decode stalls. The stage also handles PC redirects from the memory stage and halt retirement.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset.
- `NOP_INST`, default 16'h0800: instruction driven whenever `inst_valid`=0.

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `stall_in`  in  1  decode hazard stall; hold the current head instruction
- `redirect_in`  in  1  taken branch/jump from the memory stage
- `redirect_pc`  in  16  new PC (memory stage `newPC`)
- `halt_in`  in  1  halt retired; stop fetching
- `imem_req`  out  1  fetch request
- `imem_addr`  out  16  fetch address, always equal to the PC
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response data valid
- `imem_rdata`  in  16  fetched instruction
- `inst_valid`  out  1  `instruction`/`pc_next` valid for IF_ID
- `instruction`  out  16  buffer head, or `NOP_INST`
- `pc_next`  out  16  fetch address of the head + 2
- `err`  out  1  sticky fetch error (see Configuration)

## Operation
- FSM states: RUN, WAIT, DRAIN, HALTED. Reset state is RUN.
- **RUN**
  - `imem_req`=1 when `count + outstanding < 2`.
  - On `imem_gnt`: PC <= PC+2 (wraps mod 2^16), outstanding=1, next state WAIT.
- **WAIT**
  - On `imem_rvalid`: push `{imem_rdata, issued_addr+2}` into the buffer; outstanding=0.
  - A new request may issue in the same cycle as `imem_rvalid`, space permitting; the next state is then WAIT, otherwise RUN.
- **DRAIN**
  - Entered on a redirect while a request is outstanding.
  - The next `imem_rvalid` is discarded, then the FSM goes to RUN.
  - `imem_req`=0 while in DRAIN.
- **HALTED**
  - `imem_req`=0; the buffer is flushed.
  - `inst_valid`=0 permanently; `imem_rvalid` is ignored.
  - Only reset exits HALTED.
- **Buffer:** 2-entry FIFO, head presented combinationally.
  - Pop when `inst_valid && !stall_in`.
  - Push and pop in the same cycle are allowed at any count.
- **Redirect** (`redirect_in`=1):
  - PC <= `redirect_pc`; buffer flushed; `imem_req` is forced to 0 that cycle.
  - Next state is DRAIN if a request is outstanding or `imem_gnt` occurs that cycle; otherwise RUN.
- **Priority:** halt > redirect > stall.
  - Redirect with stall in the same cycle: the redirect takes effect.
  - Halt with redirect: the redirect is ignored.
- **Reset outputs:** `imem_req`=0 while reset is asserted, `imem_addr`=`RESET_PC`, `inst_valid`=0, `instruction`=`NOP_INST`, `pc_next`=`RESET_PC`+2, `err`=0.
- **Reset mid-request:** the pending response is lost; memory must tolerate an abandoned request.

## Timing
- First `imem_req` is in the first cycle after `rst` deasserts.
- **Zero-wait memory** (`gnt` with `req`, `rvalid` one cycle later):
  - req at cycle t, `inst_valid` at t+2.
  - Throughput is 1 instruction/cycle with no stalls.
- **Redirect at cycle t:**
  - `inst_valid`=0 from t+1.
  - First request to `redirect_pc` at t+1 if nothing was outstanding.
- **Stall:** `instruction`/`pc_next` stay stable while `stall_in`=1.
  - Fetching continues until the buffer plus outstanding request reach 2.
  - The buffer never overflows and no response is dropped except in DRAIN.
- **Empty buffer:** `inst_valid`=0, `instruction`=`NOP_INST`.
- **Halt at cycle t:** no `imem_req` from t onward.

## Configuration
- `FETCH_ALIGN_CHECK_EN`
  - **Defined:** a redirect with `redirect_pc[0]`=1 sets `err` (sticky until reset). That redirect is still taken, with bit 0 forced to 0.
  - **Undefined:** `err` is tied 0 and `redirect_pc` is used unmodified.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum (RUN, WAIT, DRAIN, HALTED)
  - `fetch_entry_t` struct `{instr[15:0], pc_next[15:0]}`
  - constants `FETCH_NOP` (16'h0800) and `FETCH_BUF_DEPTH` (2)
- Sub-module `fetch_inst_buf`: 2-entry FIFO of `fetch_entry_t`.
  - Inputs: push, pop, flush.
  - Outputs: count, head.

## Test plan
- **Reset and streaming:** release `rst`; memory returns 16'h1111 and 16'h2222 at 0/2 with zero-wait. Expected: `inst_valid` at cycle 2; `instruction`=16'h1111, `pc_next`=16'h0002, then 16'h2222, `pc_next`=16'h0004 on consecutive cycles.
- **Stall fills buffer:** hold `stall_in` 5 cycles. Expected: at most 2 requests beyond the head; `imem_req`=0 once full; on release, heads are drained in order with no loss.
- **Redirect with request outstanding:** `gnt` delayed, `redirect_pc`=16'h0040. Expected: the stale `rvalid` data is discarded; the next request address is 16'h0040; `inst_valid`=0 until its data arrives.
- **Simultaneous events:** redirect+stall → redirect taken, buffer flushed. Halt+redirect → HALTED, no further `imem_req`, `instruction`=16'h0800.
- **Reset mid-WAIT:** assert `rst` with a request outstanding. Expected: outputs return to reset values immediately; a late `imem_rvalid` after release is not buffered before the first new request.
- **With `FETCH_ALIGN_CHECK_EN`:** `redirect_pc`=16'h0013. Expected: `err`=1 and sticky; the next fetch is from 16'h0012.
